// File: rtl/alu_cond_unit.sv
// rtl/alu_cond_unit.sv - ALU condition evaluation, flag register and skid-buffered output stage
module alu_cond_unit #(
  parameter int N     = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic [3:0]       in_flags,
  input  logic [3:0]       in_cond,
  input  logic             in_flag_write,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exec,
  output logic [3:0]       flags_q
);

  logic             skid_valid;
  logic [N-1:0]     skid_result;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_exec;

  logic accept;
  logic pass;
  logic out_free;
  logic f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = flags_q;
  assign accept   = in_valid & in_ready & ~flush;
  // Output register can take a new entry this cycle when empty or being drained.
  assign out_free = ~out_valid | out_ready;

  always_comb begin
    pass = 1'b0;
    case (in_cond)
      4'd0:  pass = f_z;
      4'd1:  pass = ~f_z;
      4'd2:  pass = f_c;
      4'd3:  pass = ~f_c;
      4'd4:  pass = f_n;
      4'd5:  pass = ~f_n;
      4'd6:  pass = f_v;
      4'd7:  pass = ~f_v;
      4'd8:  pass = f_c & ~f_z;
      4'd9:  pass = ~f_c | f_z;
      4'd10: pass = (f_n == f_v);
      4'd11: pass = (f_n != f_v);
      4'd12: pass = ~f_z & (f_n == f_v);
      4'd13: pass = f_z | (f_n != f_v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_exec    <= 1'b0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_tag    <= '0;
      skid_exec   <= 1'b0;
      in_ready    <= 1'b1;
      flags_q     <= 4'b0000;
    end else begin
      if (accept && pass && in_flag_write)
        flags_q <= in_flags;

      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (out_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_result <= skid_result;
          out_tag    <= skid_tag;
          out_exec   <= skid_exec;
          if (accept) begin
            skid_result <= in_result;
            skid_tag    <= in_tag;
            skid_exec   <= pass;
          end else begin
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
          end
        end else begin
          out_valid <= accept;
          if (accept) begin
            out_result <= in_result;
            out_tag    <= in_tag;
            out_exec   <= pass;
          end
        end
      end else if (accept) begin
        // Output stalled; accept implies the skid entry is empty.
        skid_valid  <= 1'b1;
        skid_result <= in_result;
        skid_tag    <= in_tag;
        skid_exec   <= pass;
        in_ready    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cond_unit.sv
// tb/tb_alu_cond_unit.sv - directed self-checking bench for alu_cond_unit
module tb_alu_cond_unit;

  localparam int N     = 24;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_result;
  logic [3:0]       in_flags;
  logic [3:0]       in_cond;
  logic             in_flag_write;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_exec;
  logic [3:0]       flags_q;

  int n_vec = 0;
  int n_err = 0;

  alu_cond_unit #(.N(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_cond(in_cond), .in_flag_write(in_flag_write),
    .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_exec(out_exec), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] f, input logic fw,
                       input logic [TAG_W-1:0] t, input logic [N-1:0] r);
    in_valid      = 1'b1;
    in_cond       = c;
    in_flags      = f;
    in_flag_write = fw;
    in_tag        = t;
    in_result     = r;
  endtask

  task automatic send(input logic [3:0] c, input logic [3:0] f, input logic fw,
                      input logic [TAG_W-1:0] t, input logic [N-1:0] r);
    drive(c, f, fw, t, r);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_cond = '0;
    in_flag_write = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_flags", 32'(flags_q), 0);
    check("rst_out_result", 32'(out_result), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_out_exec", 32'(out_exec), 0);
    rst = 1'b1;
    tick(); tick(); tick();
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_flags", 32'(flags_q), 0);

    // Flag write with AL, then back-to-back conditional ops
    send(4'd14, 4'b0100, 1'b1, 4'd1, 24'h000111);
    check("al_flags", 32'(flags_q), 32'h4);
    check("al_exec", 32'(out_exec), 1);
    check("al_valid", 32'(out_valid), 1);
    check("al_tag", 32'(out_tag), 1);
    check("al_result", 32'(out_result), 32'h111);
    send(4'd0, 4'b0000, 1'b0, 4'd2, 24'h000222);
    check("eq_exec", 32'(out_exec), 1);
    check("eq_tag", 32'(out_tag), 2);
    send(4'd1, 4'b0000, 1'b0, 4'd3, 24'h000333);
    check("ne_exec", 32'(out_exec), 0);
    check("ne_tag", 32'(out_tag), 3);
    send(4'd1, 4'b1000, 1'b1, 4'd4, 24'h000444);
    check("ne_fw_exec", 32'(out_exec), 0);
    check("ne_fw_flags", 32'(flags_q), 32'h4);

    // Signed and unsigned conditions
    send(4'd14, 4'b1000, 1'b1, 4'd0, 24'h0);
    check("set_1000", 32'(flags_q), 32'h8);
    send(4'd10, 4'b0, 1'b0, 4'd0, 24'h0); check("ge_1000", 32'(out_exec), 0);
    send(4'd11, 4'b0, 1'b0, 4'd0, 24'h0); check("lt_1000", 32'(out_exec), 1);
    send(4'd13, 4'b0, 1'b0, 4'd0, 24'h0); check("le_1000", 32'(out_exec), 1);
    send(4'd12, 4'b0, 1'b0, 4'd0, 24'h0); check("gt_1000", 32'(out_exec), 0);
    send(4'd4,  4'b0, 1'b0, 4'd0, 24'h0); check("mi_1000", 32'(out_exec), 1);
    send(4'd15, 4'b0, 1'b0, 4'd0, 24'h0); check("nv_1000", 32'(out_exec), 0);
    send(4'd14, 4'b1001, 1'b1, 4'd0, 24'h0);
    check("set_1001", 32'(flags_q), 32'h9);
    send(4'd10, 4'b0, 1'b0, 4'd0, 24'h0); check("ge_1001", 32'(out_exec), 1);
    send(4'd12, 4'b0, 1'b0, 4'd0, 24'h0); check("gt_1001", 32'(out_exec), 1);
    send(4'd6,  4'b0, 1'b0, 4'd0, 24'h0); check("vs_1001", 32'(out_exec), 1);
    send(4'd14, 4'b0110, 1'b1, 4'd0, 24'h0);
    check("set_0110", 32'(flags_q), 32'h6);
    send(4'd8,  4'b0, 1'b0, 4'd0, 24'h0); check("hi_0110", 32'(out_exec), 0);
    send(4'd9,  4'b0, 1'b0, 4'd0, 24'h0); check("ls_0110", 32'(out_exec), 1);
    send(4'd2,  4'b0, 1'b0, 4'd0, 24'h0); check("cs_0110", 32'(out_exec), 1);
    send(4'd3,  4'b0, 1'b0, 4'd0, 24'h0); check("cc_0110", 32'(out_exec), 0);
    send(4'd5,  4'b0, 1'b0, 4'd0, 24'h0); check("pl_0110", 32'(out_exec), 1);
    send(4'd7,  4'b0, 1'b0, 4'd0, 24'h0); check("vc_0110", 32'(out_exec), 1);
    send(4'd15, 4'b0, 1'b0, 4'd0, 24'h0); check("nv_0110", 32'(out_exec), 0);
    tick();
    check("drained_valid", 32'(out_valid), 0);

    // Backpressure: tags 1,2 buffered, tag 3 held, then drain in order
    out_ready = 1'b0;
    send(4'd14, 4'b0, 1'b0, 4'd1, 24'h0000a1);
    check("bp1_valid", 32'(out_valid), 1);
    check("bp1_in_ready", 32'(in_ready), 1);
    send(4'd14, 4'b0, 1'b0, 4'd2, 24'h0000a2);
    check("bp2_in_ready", 32'(in_ready), 0);
    check("bp2_tag", 32'(out_tag), 1);
    drive(4'd14, 4'b0, 1'b0, 4'd3, 24'h0000a3);
    tick();
    check("bp_hold_in_ready", 32'(in_ready), 0);
    check("bp_hold_tag", 32'(out_tag), 1);
    check("bp_hold_result", 32'(out_result), 32'ha1);
    out_ready = 1'b1;
    tick();
    check("bp_out2_valid", 32'(out_valid), 1);
    check("bp_out2_tag", 32'(out_tag), 2);
    check("bp_out2_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_out3_valid", 32'(out_valid), 1);
    check("bp_out3_tag", 32'(out_tag), 3);
    check("bp_out3_result", 32'(out_result), 32'ha3);
    tick();
    check("bp_empty", 32'(out_valid), 0);

    // Flush with skid full and an op presented
    out_ready = 1'b0;
    send(4'd14, 4'b0, 1'b0, 4'd4, 24'h0);
    send(4'd14, 4'b0, 1'b0, 4'd5, 24'h0);
    check("fl_full_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(4'd14, 4'b1111, 1'b1, 4'd6, 24'h0);
    tick();
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_in_ready", 32'(in_ready), 1);
    check("fl_flags", 32'(flags_q), 32'h6);
    // Flush while ready: the presented op must still be ignored
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2_out_valid", 32'(out_valid), 0);
    check("fl2_flags", 32'(flags_q), 32'h6);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    send(4'd14, 4'b0, 1'b0, 4'd7, 24'h0000b7);
    send(4'd14, 4'b0, 1'b0, 4'd8, 24'h0000b8);
    check("pre_rst_in_ready", 32'(in_ready), 0);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_flags", 32'(flags_q), 0);
    check("arst_tag", 32'(out_tag), 0);
    check("arst_result", 32'(out_result), 0);
    check("arst_exec", 32'(out_exec), 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cond_unit.md
# alu_cond_unit

Execute-stage back end of the scalar ALU. Each accepted ALU op carries its result, its NZCV flags and a 4-bit condition code. The block holds the architectural flag register, evaluates the condition against the committed flags, and records whether the op executes. It passes result, tag and execute bit to the memory stage through a valid/ready pipeline stage with a one-entry skid buffer.

## Interface
- N, default 24: data width of the ALU result.
- TAG_W, default 4: width of the destination tag carried alongside the result.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU op presented.
- in_ready  output  1  block can accept an op this cycle; registered, equals !skid_valid.
- in_result  input  N  ALU result.
- in_flags  input  4  ALU flags {n, z, c, v}.
- in_cond  input  4  condition code.
- in_flag_write  input  1  op updates the flag register if it executes.
- in_tag  input  TAG_W  destination tag.
- flush  input  1  discard all buffered ops and ignore the input this cycle.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the output entry.
- out_result  output  N  buffered result.
- out_tag  output  TAG_W  buffered tag.
- out_exec  output  1  condition passed; downstream suppresses writeback when 0.
- flags_q  output  4  committed {N, Z, C, V} flag register.

## Operation
Accept rule:
- An op is accepted when in_valid & in_ready & !flush.
- The condition is evaluated combinationally against flags_q, never against in_flags.

Condition codes:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C & !Z
- 9 LS: !C | Z
- 10 GE: N==V
- 11 LT: N!=V
- 12 GT: !Z & (N==V)
- 13 LE: Z | (N!=V)
- 14 AL: 1
- 15 NV: 0

Flag write:
- flags_q <= in_flags only on accept & pass & in_flag_write.
- A failed or non-writing op leaves flags_q unchanged.
- Flags commit at acceptance. The next accepted op, even back-to-back, sees them.

Buffering (output register plus one skid entry):
- Accept while the output register is empty or draining (out_ready=1): the op goes to the output register.
- Accept while out_valid & !out_ready: the op goes to the skid entry.
- When out_ready=1 and the skid entry is valid: the skid entry moves to the output register and the skid entry empties.
- in_ready = !skid_valid, registered.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.

Flush:
- Clears out_valid and skid_valid at the next edge.
- Blocks acceptance in the same cycle.
- flags_q is not rolled back.

Reset (asynchronous assert, synchronous release):
- out_valid=0, skid_valid=0, in_ready=1, flags_q=4'b0000, out_result=0, out_tag=0, out_exec=0.
- Reset mid-operation discards all entries.

## Timing
- Latency: an op accepted at edge k appears on the out_* ports after edge k with out_valid=1.
- Throughput: one op per cycle while out_ready=1.
- Output stability: out_* payload is stable while out_valid & !out_ready.
- in_ready:
  - Falls one cycle after the skid entry fills.
  - Rises the cycle after the skid entry drains.
  - Never depends combinationally on out_ready.
- Same-cycle drain and accept: output empties and input is accepted in the same cycle.
  - If the skid entry is valid, the skid entry moves to output and the new op goes to skid.
  - Otherwise the new op goes directly to output.
- Flush priority: flush beats simultaneous accept and drain. With flush=1, an out_ready handshake on that cycle is ignored.

## Test plan
- Reset, then idle:
  - out_valid=0, in_ready=1, flags_q=0000 held.
  - rst asserted mid-stream with 2 entries buffered: all outputs return to reset values immediately.
- AL op with flag_write=1, in_flags=0100: next cycle flags_q=0100, out_exec=1. Then, back-to-back with out_ready=1:
  - EQ gives out_exec=1.
  - NE gives out_exec=0.
- flags_q=0100, cond=NE, flag_write=1, in_flags=1000: out_exec=0, flags_q stays 0100.
- Signed conditions:
  - flags_q=1000: GE=0, LT=1, LE=1, GT=0.
  - flags_q=1001: GE=1, GT=1.
  - flags_q=0110: HI=0, LS=1.
  - NV=0 always.
- Backpressure, with out_ready=0:
  - Ops tagged 1 and 2 accepted; in_ready=0 the cycle after the second accept.
  - Tag 3 held on the input.
  - Raise out_ready: outputs tags 1, 2, 3 in order, no gaps after the first.
- Skid buffer full and flush=1 with in_valid=1:
  - Next cycle out_valid=0, in_ready=1.
  - The input op is not accepted; flags_q is unchanged.
